// File: rtl/score_sum_readout.sv
// score_sum_readout: walks every score_sum bank entry in bank-major order
// after diffusion, streams (global node id, score) on a valid/ready port and
// optionally clears each entry to zero once it has been accepted.
// Ports: clk, rst_n (async, active-low), start (pulse from finished_all);
//   BRAM side: mem_data_in_score_sum (read data), mem_addr_score_sum,
//   mem_data_out_score_out_sum (always 0), mem_score_write_sum_en;
//   stream side: out_valid/out_ready, out_node, out_score, out_last;
//   status: busy (not IDLE), done (one-cycle completion pulse).
module score_sum_readout #(
   parameter int DATA_WIDTH    = 32,
   parameter int ADDR_WIDTH    = 13,
   parameter int PARALLEL      = 4,
   parameter int node_num      = 5,
   parameter bit CLEAR_ON_READ = 1'b1
) (
   input  logic                           clk,
   input  logic                           rst_n,
   input  logic                           start,
   input  logic [DATA_WIDTH*PARALLEL-1:0] mem_data_in_score_sum,
   output logic [ADDR_WIDTH*PARALLEL-1:0] mem_addr_score_sum,
   output logic [DATA_WIDTH*PARALLEL-1:0] mem_data_out_score_out_sum,
   output logic [PARALLEL-1:0]            mem_score_write_sum_en,
   output logic                           out_valid,
   input  logic                           out_ready,
   output logic [ADDR_WIDTH-1:0]          out_node,
   output logic [DATA_WIDTH-1:0]          out_score,
   output logic                           out_last,
   output logic                           busy,
   output logic                           done
);

   localparam int AW = (node_num > 1) ? $clog2(node_num) : 1;
   localparam int BW = (PARALLEL > 1) ? $clog2(PARALLEL) : 1;
   localparam logic [AW-1:0] A_LAST = AW'(node_num - 1);
   localparam logic [BW-1:0] B_LAST = BW'(PARALLEL - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_CAPTURE,
      S_PRESENT,
      S_CLEAR,
      S_DONE
   } state_t;

   state_t                         state_q;
   logic [AW-1:0]                  a_q, a_d;
   logic [BW-1:0]                  b_q, b_d;
   logic [ADDR_WIDTH*PARALLEL-1:0] addr_q, addr_d;
   logic [PARALLEL-1:0]            we_q;
   logic                           valid_q;
   logic [ADDR_WIDTH-1:0]          node_q, node_d;
   logic [DATA_WIDTH-1:0]          score_q, score_d;
   logic                           last_q, last_d;
   logic                           busy_q;
   logic                           done_q;
   logic                           hs;

   // Next walk position and the address vector that goes with it, so the
   // address register already holds the next entry when ISSUE is entered.
   always_comb begin
      a_d = (a_q == A_LAST) ? '0 : a_q + 1'b1;
      b_d = (a_q == A_LAST) ? b_q + 1'b1 : b_q;
      addr_d = '0;
      addr_d[int'(b_d)*ADDR_WIDTH +: ADDR_WIDTH] = ADDR_WIDTH'(a_d);
      score_d = mem_data_in_score_sum[int'(b_q)*DATA_WIDTH +: DATA_WIDTH];
      node_d = ADDR_WIDTH'(b_q) * ADDR_WIDTH'(node_num)
             + ADDR_WIDTH'(a_q);
      last_d = (b_q == B_LAST) && (a_q == A_LAST);
      hs = valid_q & out_ready;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         a_q     <= '0;
         b_q     <= '0;
         addr_q  <= '0;
         we_q    <= '0;
         valid_q <= 1'b0;
         node_q  <= '0;
         score_q <= '0;
         last_q  <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         we_q   <= '0;
         unique case (state_q)
            S_IDLE: begin
               if (start) begin
                  a_q     <= '0;
                  b_q     <= '0;
                  addr_q  <= '0;
                  busy_q  <= 1'b1;
                  state_q <= S_ISSUE;
               end
            end
            S_ISSUE: begin
               state_q <= S_CAPTURE;
            end
            S_CAPTURE: begin
               score_q <= score_d;
               node_q  <= node_d;
               last_q  <= last_d;
               valid_q <= 1'b1;
               state_q <= S_PRESENT;
            end
            S_PRESENT: begin
               if (hs) begin
                  valid_q <= 1'b0;
                  if (CLEAR_ON_READ) begin
                     // address is still held, so the clear hits this entry
                     we_q[b_q] <= 1'b1;
                     state_q   <= S_CLEAR;
                  end else if (last_q) begin
                     addr_q  <= '0;
                     last_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     a_q     <= a_d;
                     b_q     <= b_d;
                     addr_q  <= addr_d;
                     state_q <= S_ISSUE;
                  end
               end
            end
            S_CLEAR: begin
               if (last_q) begin
                  addr_q  <= '0;
                  last_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_DONE;
               end else begin
                  a_q     <= a_d;
                  b_q     <= b_d;
                  addr_q  <= addr_d;
                  state_q <= S_ISSUE;
               end
            end
            S_DONE: begin
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign mem_addr_score_sum         = addr_q;
   assign mem_data_out_score_out_sum = '0;
   assign mem_score_write_sum_en     = we_q;
   assign out_valid                  = valid_q;
   assign out_node                   = node_q;
   assign out_score                  = score_q;
   assign out_last                   = last_q;
   assign busy                       = busy_q;
   assign done                       = done_q;

endmodule

// File: tb/tb_score_sum_readout.sv
// tb_score_sum_readout: randomized self-checking bench for score_sum_readout,
// one clearing and one non-clearing instance, each with its own BRAM model.
module tb_score_sum_readout;

   localparam int DW  = 32;
   localparam int AW  = 13;
   localparam int P   = 4;
   localparam int N   = 5;
   localparam int E   = P * N;
   localparam int AWP = AW * P;

   logic clk = 1'b0;
   logic rst_n = 1'b1;
   always #5 clk = ~clk;

   logic start_c = 1'b0, ready_c = 1'b1;
   logic start_n = 1'b0, ready_n = 1'b1;
   logic [DW*P-1:0] rd_c, rd_n, wd_c, wd_n;
   logic [AWP-1:0]  addr_c, addr_n;
   logic [P-1:0]    we_c, we_n;
   logic            vld_c, vld_n, lst_c, lst_n;
   logic            bsy_c, bsy_n, dn_c, dn_n;
   logic [AW-1:0]   nd_c, nd_n;
   logic [DW-1:0]   sc_c, sc_n;

   score_sum_readout #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARALLEL(P),
      .node_num(N), .CLEAR_ON_READ(1'b1)
   ) dut_c (
      .clk(clk), .rst_n(rst_n), .start(start_c),
      .mem_data_in_score_sum(rd_c),
      .mem_addr_score_sum(addr_c),
      .mem_data_out_score_out_sum(wd_c),
      .mem_score_write_sum_en(we_c),
      .out_valid(vld_c), .out_ready(ready_c),
      .out_node(nd_c), .out_score(sc_c), .out_last(lst_c),
      .busy(bsy_c), .done(dn_c)
   );

   score_sum_readout #(
      .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .PARALLEL(P),
      .node_num(N), .CLEAR_ON_READ(1'b0)
   ) dut_n (
      .clk(clk), .rst_n(rst_n), .start(start_n),
      .mem_data_in_score_sum(rd_n),
      .mem_addr_score_sum(addr_n),
      .mem_data_out_score_out_sum(wd_n),
      .mem_score_write_sum_en(we_n),
      .out_valid(vld_n), .out_ready(ready_n),
      .out_node(nd_n), .out_score(sc_n), .out_last(lst_n),
      .busy(bsy_n), .done(dn_n)
   );

   // BRAM models: synchronous read-first, one-cycle latency
   logic [DW-1:0] mem [2][P][8];
   logic [DW-1:0] img [2][P][8];
   bit            load_req [2];

   always @(posedge clk) begin
      for (int i = 0; i < 2; i++)
         if (load_req[i])
            for (int b = 0; b < P; b++)
               for (int a = 0; a < 8; a++)
                  mem[i][b][a] <= img[i][b][a];
      for (int b = 0; b < P; b++) begin
         rd_c[b*DW +: DW] <= mem[0][b][addr_c[b*AW +: 3]];
         rd_n[b*DW +: DW] <= mem[1][b][addr_n[b*AW +: 3]];
         if (we_c[b] && !load_req[0])
            mem[0][b][addr_c[b*AW +: 3]] <= wd_c[b*DW +: DW];
         if (we_n[b] && !load_req[1])
            mem[1][b][addr_n[b*AW +: 3]] <= wd_n[b*DW +: DW];
      end
   end

   int errors = 0;
   int checks = 0;

   logic [AW-1:0] q_node [$];
   logic [DW-1:0] q_score [$];
   logic [DW-1:0] exp_s [E];
   int wr_cnt [E];
   int first_cyc, last_cyc, done_cyc, done_cnt;
   int wr_bad, wr_tot, stall_wr, instab, stall_cyc, dl_bad;
   bit tout;

   task automatic preload(input int sel, input bit rnd);
      for (int b = 0; b < P; b++)
         for (int a = 0; a < 8; a++)
            img[sel][b][a] = rnd ? ($urandom | 32'h1) : 32'(b*N + a);
      if (!rnd) img[sel][1][2] = 32'h0000_1234;
      load_req[sel] = 1'b1;
      @(posedge clk); #1;
      load_req[sel] = 1'b0;
   endtask

   task automatic snap(input int sel);
      for (int i = 0; i < E; i++) exp_s[i] = mem[sel][i/N][i%N];
   endtask

   // Drives one readout (start in cycle 0) and records what the DUT did.
   // mode: 0 ready high, 1 stall node 3 for 5 cycles, 2 random ready.
   task automatic run(input int sel, input int mode,
                      input int rs_node, input int max_cyc);
      int c, nb, na;
      bit fin, v, lst, dn, rdy, pv, pr;
      logic [AW-1:0]  nd, pnd;
      logic [DW-1:0]  sc, psc;
      logic [P-1:0]   we;
      logic [AWP-1:0] ad, xad;
      logic [DW*P-1:0] wd;
      q_node.delete(); q_score.delete();
      first_cyc = -1; last_cyc = -1; done_cyc = -1; done_cnt = 0;
      wr_bad = 0; wr_tot = 0; stall_wr = 0; instab = 0;
      stall_cyc = 0; dl_bad = 0; tout = 0;
      for (int i = 0; i < E; i++) wr_cnt[i] = 0;
      c = 0; fin = 0; pv = 0; pr = 1; pnd = '0; psc = '0;
      while (!fin) begin
         if (sel == 1) begin
            v = vld_n; nd = nd_n; sc = sc_n; lst = lst_n;
            dn = dn_n; we = we_n; ad = addr_n; wd = wd_n;
         end else begin
            v = vld_c; nd = nd_c; sc = sc_c; lst = lst_c;
            dn = dn_c; we = we_c; ad = addr_c; wd = wd_c;
         end
         case (mode)
            0: rdy = 1'b1;
            1: rdy = !(v && nd == 3 && stall_cyc < 5);
            default: rdy = 1'($urandom_range(0, 1));
         endcase
         if (v && !rdy && mode == 1) stall_cyc++;
         if (pv && !pr && (!v || nd !== pnd || sc !== psc)) instab++;
         if (v && first_cyc < 0) first_cyc = c;
         if (v && rdy) begin
            q_node.push_back(nd);
            q_score.push_back(sc);
            if (lst) last_cyc = c;
         end
         if (v && !rdy && we != 0) stall_wr++;
         if (we != 0) begin
            wr_tot++;
            nb = int'(nd) / N;
            na = int'(nd) % N;
            xad = AWP'(na) << (nb*AW);
            if (we !== P'(1 << nb) || ad !== xad || wd !== '0) wr_bad++;
            if (int'(nd) < E) wr_cnt[int'(nd)]++;
         end
         if (dn) begin
            done_cnt++;
            done_cyc = c;
            if (lst) dl_bad++;
         end
         pv = v; pr = rdy; pnd = nd; psc = sc;
         if (sel == 1) begin
            ready_n = rdy;
            start_n = (c == 0) || (rs_node >= 0 && v && int'(nd) == rs_node);
         end else begin
            ready_c = rdy;
            start_c = (c == 0) || (rs_node >= 0 && v && int'(nd) == rs_node);
         end
         if (done_cnt > 0 && c >= done_cyc + 3) fin = 1;
         else if (c >= max_cyc) begin tout = 1; fin = 1; end
         else begin @(posedge clk); #1; c++; end
      end
      start_c = 1'b0; start_n = 1'b0; ready_c = 1'b1; ready_n = 1'b1;
   endtask

   task automatic test_reset;
      #2 rst_n = 1'b0;
      @(posedge clk); @(posedge clk); #1;
      checks++;
      if ({vld_c, lst_c, bsy_c, dn_c} !== 4'b0) begin
         errors++;
         $display("FAIL reset_flags: got %b want 0000",
                  {vld_c, lst_c, bsy_c, dn_c});
      end
      checks++;
      if (nd_c !== '0 || sc_c !== '0) begin
         errors++;
         $display("FAIL reset_data: got node=%0d score=%h want 0 0", nd_c, sc_c);
      end
      checks++;
      if (addr_c !== '0 || we_c !== '0) begin
         errors++;
         $display("FAIL reset_mem: got addr=%h we=%b want 0", addr_c, we_c);
      end
      checks++;
      if ({vld_n, lst_n, bsy_n, dn_n, nd_n, sc_n, addr_n, we_n} !== '0) begin
         errors++;
         $display("FAIL reset_noclear: got valid=%b busy=%b addr=%h want 0",
                  vld_n, bsy_n, addr_n);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_readout_clear;
      preload(0, 1'b0);
      for (int i = 0; i < E; i++)
         exp_s[i] = (i == 7) ? 32'h0000_1234 : 32'(i);
      run(0, 0, -1, 300);
      checks++;
      if (tout || q_node.size() != E) begin
         errors++;
         $display("FAIL clr_beats: got %0d beats timeout=%b want %0d",
                  q_node.size(), tout, E);
      end
      for (int i = 0; i < E && i < q_node.size(); i++) begin
         checks++;
         if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL clr_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                     i, q_node[i], q_score[i], i, exp_s[i]);
         end
      end
      checks++;
      if (q_score.size() < 8 || q_score[7] !== 32'h0000_1234) begin
         errors++;
         $display("FAIL clr_node7: got %h want 00001234",
                  (q_score.size() < 8) ? 32'hx : q_score[7]);
      end
      checks++;
      if (first_cyc != 3 || last_cyc != 79 || done_cyc != 81) begin
         errors++;
         $display("FAIL clr_timing: got first=%0d last=%0d done=%0d want 3 79 81",
                  first_cyc, last_cyc, done_cyc);
      end
      checks++;
      if (done_cnt != 1 || dl_bad != 0) begin
         errors++;
         $display("FAIL clr_done: got pulses=%0d last_at_done=%0d want 1 0",
                  done_cnt, dl_bad);
      end
      checks++;
      if (wr_bad != 0) begin
         errors++;
         $display("FAIL clr_wr_target: got %0d bad writes want 0", wr_bad);
      end
      for (int i = 0; i < E; i++) begin
         checks++;
         if (mem[0][i/N][i%N] !== '0 || wr_cnt[i] != 1) begin
            errors++;
            $display("FAIL clr_entry%0d: got mem=%h writes=%0d want 0 1",
                     i, mem[0][i/N][i%N], wr_cnt[i]);
         end
      end
   endtask

   task automatic test_readout_noclear;
      preload(1, 1'b0);
      for (int i = 0; i < E; i++)
         exp_s[i] = (i == 7) ? 32'h0000_1234 : 32'(i);
      run(1, 0, -1, 300);
      checks++;
      if (tout || q_node.size() != E) begin
         errors++;
         $display("FAIL nc_beats: got %0d beats timeout=%b want %0d",
                  q_node.size(), tout, E);
      end
      for (int i = 0; i < E && i < q_node.size(); i++) begin
         checks++;
         if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL nc_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                     i, q_node[i], q_score[i], i, exp_s[i]);
         end
      end
      checks++;
      if (first_cyc != 3 || last_cyc != 60 || done_cyc != 61 || done_cnt != 1) begin
         errors++;
         $display("FAIL nc_timing: got first=%0d last=%0d done=%0d pulses=%0d want 3 60 61 1",
                  first_cyc, last_cyc, done_cyc, done_cnt);
      end
      checks++;
      if (wr_tot != 0) begin
         errors++;
         $display("FAIL nc_writes: got %0d writes want 0", wr_tot);
      end
      for (int i = 0; i < E; i++) begin
         checks++;
         if (mem[1][i/N][i%N] !== exp_s[i]) begin
            errors++;
            $display("FAIL nc_mem%0d: got %h want %h", i, mem[1][i/N][i%N], exp_s[i]);
         end
      end
   endtask

   task automatic test_backpressure;
      preload(0, 1'b1);
      snap(0);
      run(0, 1, -1, 300);
      checks++;
      if (tout || q_node.size() != E) begin
         errors++;
         $display("FAIL bp_beats: got %0d beats timeout=%b want %0d",
                  q_node.size(), tout, E);
      end
      for (int i = 0; i < E && i < q_node.size(); i++) begin
         checks++;
         if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL bp_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                     i, q_node[i], q_score[i], i, exp_s[i]);
         end
      end
      checks++;
      if (stall_cyc != 5 || instab != 0 || stall_wr != 0) begin
         errors++;
         $display("FAIL bp_stall: got stall=%0d unstable=%0d writes=%0d want 5 0 0",
                  stall_cyc, instab, stall_wr);
      end
      checks++;
      if (last_cyc != 84 || done_cyc != 86 || done_cnt != 1 || wr_bad != 0) begin
         errors++;
         $display("FAIL bp_timing: got last=%0d done=%0d pulses=%0d badwr=%0d want 84 86 1 0",
                  last_cyc, done_cyc, done_cnt, wr_bad);
      end
   endtask

   task automatic test_back_to_back;
      preload(0, 1'b1);
      snap(0);
      run(0, 0, 6, 300);
      checks++;
      if (tout || q_node.size() != E || done_cnt != 1 || done_cyc != 81) begin
         errors++;
         $display("FAIL restart: got beats=%0d pulses=%0d done=%0d timeout=%b want %0d 1 81 0",
                  q_node.size(), done_cnt, done_cyc, tout, E);
      end
      for (int i = 0; i < E && i < q_node.size(); i++) begin
         checks++;
         if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL restart_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                     i, q_node[i], q_score[i], i, exp_s[i]);
         end
      end
   endtask

   task automatic test_random_ready;
      for (int sel = 0; sel < 2; sel++) begin
         preload(sel, 1'b1);
         snap(sel);
         run(sel, 2, -1, 3000);
         checks++;
         if (tout || q_node.size() != E || done_cnt != 1) begin
            errors++;
            $display("FAIL rnd%0d_beats: got beats=%0d pulses=%0d timeout=%b want %0d 1 0",
                     sel, q_node.size(), done_cnt, tout, E);
         end
         for (int i = 0; i < E && i < q_node.size(); i++) begin
            checks++;
            if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
               errors++;
               $display("FAIL rnd%0d_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                        sel, i, q_node[i], q_score[i], i, exp_s[i]);
            end
         end
         for (int i = 0; i < E; i++) begin
            checks++;
            if (mem[sel][i/N][i%N] !== ((sel == 0) ? '0 : exp_s[i])) begin
               errors++;
               $display("FAIL rnd%0d_mem%0d: got %h want %h", sel, i,
                        mem[sel][i/N][i%N], (sel == 0) ? '0 : exp_s[i]);
            end
         end
         checks++;
         if (instab != 0 || wr_bad != 0 || wr_tot != ((sel == 0) ? E : 0)) begin
            errors++;
            $display("FAIL rnd%0d_proto: got unstable=%0d badwr=%0d writes=%0d want 0 0 %0d",
                     sel, instab, wr_bad, wr_tot, (sel == 0) ? E : 0);
         end
      end
   endtask

   task automatic test_reset_mid_clear;
      logic [DW-1:0] pre4;
      bit found;
      preload(0, 1'b1);
      pre4 = img[0][0][4];
      found = 0;
      start_c = 1'b1; ready_c = 1'b1;
      @(posedge clk); #1;
      start_c = 1'b0;
      for (int c = 0; c < 100 && !found; c++) begin
         if (we_c != 0 && nd_c == 4) found = 1;
         else begin @(posedge clk); #1; end
      end
      checks++;
      if (!found) begin
         errors++;
         $display("FAIL rst_find_clear: got no clear of node 4 want one");
      end
      rst_n = 1'b0;
      #1;
      checks++;
      if ({vld_c, lst_c, bsy_c, dn_c, nd_c, sc_c, addr_c, we_c} !== '0) begin
         errors++;
         $display("FAIL rst_async: got valid=%b busy=%b we=%b addr=%h want 0",
                  vld_c, bsy_c, we_c, addr_c);
      end
      @(posedge clk); #1;
      checks++;
      if (mem[0][0][4] !== pre4) begin
         errors++;
         $display("FAIL rst_node4_mem: got %h want %h", mem[0][0][4], pre4);
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      snap(0);
      run(0, 0, -1, 300);
      checks++;
      if (tout || q_node.size() != E || q_node[0] !== '0) begin
         errors++;
         $display("FAIL rst_rerun: got beats=%0d first=%0d timeout=%b want %0d 0 0",
                  q_node.size(), (q_node.size() > 0) ? q_node[0] : '1, tout, E);
      end
      checks++;
      if (q_score.size() < 5 || q_score[4] !== pre4) begin
         errors++;
         $display("FAIL rst_node4_score: got %h want %h",
                  (q_score.size() < 5) ? 32'hx : q_score[4], pre4);
      end
      for (int i = 0; i < E && i < q_node.size(); i++) begin
         checks++;
         if (q_node[i] !== AW'(i) || q_score[i] !== exp_s[i]) begin
            errors++;
            $display("FAIL rst_beat%0d: got node=%0d score=%h want node=%0d score=%h",
                     i, q_node[i], q_score[i], i, exp_s[i]);
         end
      end
   endtask

   initial begin
      test_reset();
      test_readout_clear();
      test_readout_noclear();
      test_backpressure();
      test_back_to_back();
      test_random_ready();
      test_reset_mid_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5ms;
      $display("FAIL watchdog: got no completion want finish");
      $fatal(1, "watchdog");
   end

endmodule
